hex_key_entry: RTL

- Input-side counterpart of the seven-segment digit decoder: turns raw pushbutton presses into debounced 4-bit hex digits and accumulates them into an 8-digit entry word.
- The entry word feeds the display decoders one nibble per digit.
- Sits between the board's pb[20:0] bank and any datapath needing typed-in values; clocked by hz100.

---
 rtl/hex_key_entry_pkg.sv | 17 +
 rtl/hex_key_entry_prio_enc.sv | 17 +
 rtl/hex_key_entry.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hex_key_entry_pkg.sv
// Shared types and key-code constants for the hex keypad entry block.
package hex_key_pkg;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} key_state_t;

   localparam logic [4:0] KEY_BKSP   = 5'd16;
   localparam logic [4:0] KEY_ENTER  = 5'd17;
   localparam logic [4:0] KEY_RSVD   = 5'd18;
   localparam logic [4:0] KEY_CLEAR  = 5'd19;
   localparam logic [3:0] MAX_DIGITS = 4'd8;

   // Only digits and backspace are eligible for auto-repeat.
   function automatic logic is_repeatable(input logic [4:0] code);
      return code <= KEY_BKSP;
   endfunction

endpackage

// File: rtl/hex_key_entry_prio_enc.sv
// Priority encoder: highest set bit of the 20 key lines wins.
module pb_prio_enc (
   input  logic [19:0] keys,
   output logic [4:0]  code,
   output logic        any
);

   always_comb begin
      code = '0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (keys[i]) code = 5'(i);
      end
   end

   assign any = |keys;

endmodule

// File: rtl/hex_key_entry.sv
// Debounced pushbutton to 8-digit hex entry accumulator with commit register.
// Optional auto-repeat of held digit/backspace keys under HEX_KEY_AUTOREPEAT_EN.
module hex_key_entry
   import hex_key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2,
   parameter int unsigned REPEAT_CYCLES   = 50
) (
   input  logic        hz100,
   input  logic        reset,
   input  logic [20:0] pb,
   output logic [4:0]  key_code,
   output logic        key_strobe,
   output logic [31:0] entry,
   output logic [3:0]  ndig,
   output logic [31:0] value,
   output logic        value_valid
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 1..15");
   end
   if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 127) begin : g_bad_repeat
      $error("REPEAT_CYCLES out of range 1..127");
   end

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

   logic [20:0] sync1, s;
   logic        spare_unused;
   logic [4:0]  code;
   logic        any;

   key_state_t  state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [4:0]  cand, cand_n;
   logic [4:0]  key_code_n;
   logic        fire;
   logic [4:0]  fire_code;
   logic [31:0] entry_n, value_n;
   logic [3:0]  ndig_n;
   logic        value_valid_n;

`ifdef HEX_KEY_AUTOREPEAT_EN
   localparam logic [6:0] RPT_LAST = 7'(REPEAT_CYCLES - 1);
   logic [6:0] rpt, rpt_n;
`endif

   assign spare_unused = s[20];

   pb_prio_enc u_enc (
      .keys (s[19:0]),
      .code (code),
      .any  (any)
   );

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      cand_n     = cand;
      key_code_n = key_code;
      fire       = 1'b0;
      fire_code  = key_code;
`ifdef HEX_KEY_AUTOREPEAT_EN
      rpt_n      = rpt;
`endif
      case (state)
         IDLE: begin
            if (any) begin
               cand_n  = code;
               cnt_n   = '0;
               state_n = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!any || code != cand) begin
               state_n = IDLE;
            end else if (cnt == DB_LAST) begin
               state_n    = HELD;
               key_code_n = cand;
               fire       = 1'b1;
               fire_code  = cand;
`ifdef HEX_KEY_AUTOREPEAT_EN
               rpt_n      = '0;
`endif
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         HELD: begin
            if (!any) begin
               cnt_n   = '0;
               state_n = RELEASE;
            end
`ifdef HEX_KEY_AUTOREPEAT_EN
            else if (is_repeatable(key_code)) begin
               if (rpt == RPT_LAST) begin
                  rpt_n = '0;
                  fire  = 1'b1;
               end else begin
                  rpt_n = rpt + 7'd1;
               end
            end
`endif
         end
         RELEASE: begin
            if (any) begin
               state_n = HELD;
`ifdef HEX_KEY_AUTOREPEAT_EN
               rpt_n   = '0;
`endif
            end else if (cnt == DB_LAST) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      entry_n       = entry;
      ndig_n        = ndig;
      value_n       = value;
      value_valid_n = 1'b0;
      if (fire) begin
         if (fire_code < KEY_BKSP) begin
            // Shifting left drops the oldest nibble once all eight are full.
            entry_n = {entry[27:0], fire_code[3:0]};
            ndig_n  = (ndig < MAX_DIGITS) ? ndig + 4'd1 : MAX_DIGITS;
         end else if (fire_code == KEY_BKSP) begin
            entry_n = entry >> 4;
            ndig_n  = (ndig != '0) ? ndig - 4'd1 : '0;
         end else if (fire_code == KEY_ENTER) begin
            value_n       = entry;
            value_valid_n = 1'b1;
            entry_n       = '0;
            ndig_n        = '0;
         end else if (fire_code == KEY_CLEAR) begin
            entry_n = '0;
            ndig_n  = '0;
         end
      end
   end

   always_ff @(posedge hz100) begin
      if (!reset) begin
         sync1       <= '0;
         s           <= '0;
         state       <= IDLE;
         cnt         <= '0;
         cand        <= '0;
         key_code    <= '0;
         key_strobe  <= 1'b0;
         entry       <= '0;
         ndig        <= '0;
         value       <= '0;
         value_valid <= 1'b0;
`ifdef HEX_KEY_AUTOREPEAT_EN
         rpt         <= '0;
`endif
      end else begin
         sync1       <= pb;
         s           <= sync1;
         state       <= state_n;
         cnt         <= cnt_n;
         cand        <= cand_n;
         key_code    <= key_code_n;
         key_strobe  <= fire;
         entry       <= entry_n;
         ndig        <= ndig_n;
         value       <= value_n;
         value_valid <= value_valid_n;
`ifdef HEX_KEY_AUTOREPEAT_EN
         rpt         <= rpt_n;
`endif
      end
   end

endmodule
